// File: rtl/ppu_ctrl_pkg.sv
// Shared types and constants for the PPU sequencer (ppu_ctrl) and its output packer.
package ppu_ctrl_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int SCALE_W        = 6;
    localparam int CFG_ADDR_W     = 16;
    localparam int CFG_LEN_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrl_state_e;

    typedef struct packed {
        logic [CFG_LEN_W-1:0]  len;
        logic [CFG_ADDR_W-1:0] src;
        logic [CFG_ADDR_W-1:0] dst;
        logic [SCALE_W-1:0]    scale;
    } ppu_cfg_t;

    // Byte enables covering lanes 0..last_lane of a word.
    function automatic logic [BYTES_PER_WORD-1:0] lane_strb(input logic [1:0] last_lane);
        case (last_lane)
            2'd0:    lane_strb = 4'b0001;
            2'd1:    lane_strb = 4'b0011;
            2'd2:    lane_strb = 4'b0111;
            default: lane_strb = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ppu_ctrl_packer.sv
// ppu_out_packer: gathers 8-bit PPU results into little-endian 32-bit words and
// emits one registered write per full word, or per partial word on the last result.
module ppu_out_packer
    import ppu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic        flush_o,
    output logic        wr_en_o,
    output logic [31:0] data_o,
    output logic [3:0]  strb_o
);

    logic [1:0]  lane_q,  lane_d;
    logic [31:0] pack_q,  pack_d;
    logic        wr_en_q, wr_en_d;
    logic [31:0] data_q,  data_d;
    logic [3:0]  strb_q,  strb_d;
    logic [31:0] merged_s;
    logic        flush_s;

    // Next-state for lane index, pack register and the registered write.
    always_comb begin
        merged_s = pack_q;
        merged_s[{lane_q, 3'b000} +: 8] = byte_i;
        flush_s  = valid_i & (last_i | (lane_q == 2'd3));
        lane_d   = lane_q;
        pack_d   = pack_q;
        wr_en_d  = flush_s;
        data_d   = 32'h0000_0000;
        strb_d   = 4'b0000;
        if (flush_s) begin
            // Clearing the pack register keeps unused tail bytes at zero.
            lane_d = 2'd0;
            pack_d = 32'h0000_0000;
            data_d = merged_s;
            strb_d = lane_strb(lane_q);
        end else if (valid_i) begin
            lane_d = lane_q + 2'd1;
            pack_d = merged_s;
        end else begin
            lane_d = lane_q;
            pack_d = pack_q;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q  <= 2'd0;
            pack_q  <= 32'h0000_0000;
            wr_en_q <= 1'b0;
            data_q  <= 32'h0000_0000;
            strb_q  <= 4'b0000;
        end else begin
            lane_q  <= lane_d;
            pack_q  <= pack_d;
            wr_en_q <= wr_en_d;
            data_q  <= data_d;
            strb_q  <= strb_d;
        end
    end

    assign flush_o = flush_s;
    assign wr_en_o = wr_en_q;
    assign data_o  = data_q;
    assign strb_o  = strb_q;

endmodule

// File: rtl/ppu_ctrl.sv
// ppu_ctrl: streams psums into the PPU and writes packed 8-bit results to the output buffer.
// Optional macro PPU_CTRL_PERF_EN adds the perf_cycles busy-cycle counter port.
module ppu_ctrl
    import ppu_ctrl_pkg::*;
#(
    parameter int ADDR_W = CFG_ADDR_W,
    parameter int LEN_W  = CFG_LEN_W
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [ADDR_W-1:0]  cfg_src_base,
    input  logic [ADDR_W-1:0]  cfg_dst_base,
    input  logic [SCALE_W-1:0] cfg_scale,
    output logic               busy,
    output logic               done,
    output logic               psum_rd_en,
    output logic [ADDR_W-1:0]  psum_rd_addr,
    input  logic [31:0]        psum_rd_data,
    output logic               ppu_en,
    output logic [31:0]        ppu_data,
    output logic [SCALE_W-1:0] ppu_scale,
    input  logic               ppu_valid,
    input  logic [7:0]         ppu_out,
    output logic               ob_wr_en,
    output logic [ADDR_W-1:0]  ob_wr_addr,
    output logic [31:0]        ob_wr_data,
    output logic [3:0]         ob_wr_strb
`ifdef PPU_CTRL_PERF_EN
    ,
    output logic [31:0]        perf_cycles
`endif
);

    ctrl_state_e        state_q,    state_d;
    ppu_cfg_t           cfg_q,      cfg_d;
    logic [LEN_W-1:0]   rd_cnt_q,   rd_cnt_d;
    logic [ADDR_W-1:0]  rd_addr_q,  rd_addr_d;
    logic               rd_en_q,    rd_en_d;
    logic               ppu_en_q,   ppu_en_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;
    logic [LEN_W-1:0]   out_cnt_q,  out_cnt_d;
    logic               got_all_q,  got_all_d;
    logic [ADDR_W-1:0]  word_idx_q, word_idx_d;
    logic [ADDR_W-1:0]  wr_addr_q,  wr_addr_d;
    logic               last_wr_q,  last_wr_d;
    logic               valid_acc_s;
    logic               last_s;
    logic               flush_s;

    // Stray valids outside a run, or beyond the expected count, are dropped.
    assign valid_acc_s = ppu_valid & ((state_q == READ) | (state_q == DRAIN)) & ~got_all_q;
    assign last_s      = (out_cnt_q == (cfg_q.len - LEN_W'(1)));

    // Sequencer next-state: read issue, result counting and write addressing.
    always_comb begin
        state_d    = state_q;
        cfg_d      = cfg_q;
        rd_cnt_d   = rd_cnt_q;
        rd_addr_d  = rd_addr_q;
        rd_en_d    = 1'b0;
        out_cnt_d  = out_cnt_q;
        got_all_d  = got_all_q;
        word_idx_d = word_idx_q;
        wr_addr_d  = wr_addr_q;
        last_wr_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cfg_d      = '{len: cfg_len, src: cfg_src_base, dst: cfg_dst_base, scale: cfg_scale};
                    rd_addr_d  = cfg_src_base;
                    rd_cnt_d   = LEN_W'(1);
                    out_cnt_d  = LEN_W'(0);
                    got_all_d  = 1'b0;
                    word_idx_d = ADDR_W'(0);
                    if (cfg_len != LEN_W'(0)) begin
                        state_d = READ;
                        rd_en_d = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                if (rd_cnt_q == cfg_q.len) begin
                    state_d = DRAIN;
                end else begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = cfg_q.src + ADDR_W'(rd_cnt_q);
                    rd_cnt_d  = rd_cnt_q + LEN_W'(1);
                end
            end
            DRAIN: begin
                if (last_wr_q) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (valid_acc_s) begin
            out_cnt_d = out_cnt_q + LEN_W'(1);
            got_all_d = got_all_q | last_s;
        end else begin
            out_cnt_d = out_cnt_d;
        end

        if (flush_s) begin
            wr_addr_d  = cfg_q.dst + word_idx_q;
            word_idx_d = word_idx_q + ADDR_W'(1);
            last_wr_d  = last_s;
        end else begin
            last_wr_d  = 1'b0;
        end

        ppu_en_d = rd_en_q;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    // Sequencer registers; reset aborts any run in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cfg_q      <= '0;
            rd_cnt_q   <= LEN_W'(0);
            rd_addr_q  <= ADDR_W'(0);
            rd_en_q    <= 1'b0;
            ppu_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            out_cnt_q  <= LEN_W'(0);
            got_all_q  <= 1'b0;
            word_idx_q <= ADDR_W'(0);
            wr_addr_q  <= ADDR_W'(0);
            last_wr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cfg_q      <= cfg_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_addr_q  <= rd_addr_d;
            rd_en_q    <= rd_en_d;
            ppu_en_q   <= ppu_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            out_cnt_q  <= out_cnt_d;
            got_all_q  <= got_all_d;
            word_idx_q <= word_idx_d;
            wr_addr_q  <= wr_addr_d;
            last_wr_q  <= last_wr_d;
        end
    end

    ppu_out_packer u_packer (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_acc_s),
        .byte_i  (ppu_out),
        .last_i  (last_s),
        .flush_o (flush_s),
        .wr_en_o (ob_wr_en),
        .data_o  (ob_wr_data),
        .strb_o  (ob_wr_strb)
    );

`ifdef PPU_CTRL_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Busy-cycle counter: cleared on an accepted start, saturating.
    always_comb begin
        if ((state_q == IDLE) && start) begin
            perf_d = 32'h0000_0000;
        end else if (busy_q && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'h0000_0001;
        end else begin
            perf_d = perf_q;
        end
    end

    // Busy-cycle counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= 32'h0000_0000;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_cycles = perf_q;
`endif

    assign busy         = busy_q;
    assign done         = done_q;
    assign psum_rd_en   = rd_en_q;
    assign psum_rd_addr = rd_addr_q;
    assign ppu_en       = ppu_en_q;
    // Gated so the PPU input reads zero whenever no element is being fed.
    assign ppu_data     = ppu_en_q ? psum_rd_data : 32'h0000_0000;
    assign ppu_scale    = cfg_q.scale;
    assign ob_wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_ppu_ctrl.sv
// Self-checking bench for ppu_ctrl with a 3-cycle PPU stub and a timeline reference model.
module tb_ppu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] cfg_len = 16'h0;
    logic [15:0] cfg_src_base = 16'h0;
    logic [15:0] cfg_dst_base = 16'h0;
    logic [5:0]  cfg_scale = 6'h0;
    logic        busy, done, psum_rd_en, ppu_en, ob_wr_en, ppu_valid;
    logic [15:0] psum_rd_addr, ob_wr_addr;
    logic [31:0] psum_rd_data, ppu_data, ob_wr_data;
    logic [5:0]  ppu_scale;
    logic [7:0]  ppu_out;
    logic [3:0]  ob_wr_strb;

    ppu_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
        .cfg_src_base(cfg_src_base), .cfg_dst_base(cfg_dst_base), .cfg_scale(cfg_scale),
        .busy(busy), .done(done), .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr),
        .psum_rd_data(psum_rd_data), .ppu_en(ppu_en), .ppu_data(ppu_data),
        .ppu_scale(ppu_scale), .ppu_valid(ppu_valid), .ppu_out(ppu_out),
        .ob_wr_en(ob_wr_en), .ob_wr_addr(ob_wr_addr), .ob_wr_data(ob_wr_data),
        .ob_wr_strb(ob_wr_strb)
    );

    always #5 clk = ~clk;

    // psum buffer (1-cycle read latency) and PPU stub (data_in[7:0] 3 cycles after i_en)
    logic [31:0] mem [0:65535];
    logic [2:0]  pv = 3'b000;
    logic [7:0]  pd [0:2];
    always @(posedge clk) begin
        if (psum_rd_en) psum_rd_data <= mem[psum_rd_addr];
        pv    <= {pv[1:0], ppu_en};
        pd[0] <= ppu_data[7:0];
        pd[1] <= pd[0];
        pd[2] <= pd[1];
    end
    assign ppu_valid = pv[2];
    assign ppu_out   = pd[2];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0, n_fail = 0;
    int n_rd = 0, n_wr = 0, n_done = 0;

    // reference model: one accepted run described by its start cycle and config
    bit          run_valid = 1'b0;
    int          t0 = 0, m_len = 0;
    logic [15:0] m_src = 16'h0, m_dst = 16'h0;
    logic [5:0]  m_scale = 6'h0;

    function automatic int dur(input int l);
        return (l == 0) ? 1 : l + 6;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // every-cycle comparison against the model, 2 time units after the clock edge
    always @(posedge clk) begin
        int rel, j, w;
        logic e_busy, e_done, e_rd, e_pe, e_wr;
        logic [15:0] a;
        logic [31:0] e_data;
        #2;
        rel    = run_valid ? (cyc - t0) : -1000;
        e_busy = run_valid && rel >= 1 && rel <= dur(m_len);
        e_done = run_valid && rel == dur(m_len);
        e_rd   = run_valid && rel >= 1 && rel <= m_len;
        e_pe   = run_valid && rel >= 2 && rel <= m_len + 1;
        j      = rel - 6;
        e_wr   = run_valid && j >= 0 && j < m_len && ((j % 4) == 3 || j == m_len - 1);
        chk("busy", {31'b0, busy}, {31'b0, e_busy});
        chk("done", {31'b0, done}, {31'b0, e_done});
        chk("psum_rd_en", {31'b0, psum_rd_en}, {31'b0, e_rd});
        chk("ppu_en", {31'b0, ppu_en}, {31'b0, e_pe});
        chk("ob_wr_en", {31'b0, ob_wr_en}, {31'b0, e_wr});
        chk("ppu_scale", {26'b0, ppu_scale}, {26'b0, m_scale});
        if (e_rd) chk("psum_rd_addr", {16'b0, psum_rd_addr}, {16'b0, m_src + 16'(rel - 1)});
        if (e_pe) begin
            a = m_src + 16'(rel - 2);
            chk("ppu_data", ppu_data, mem[a]);
        end
        if (e_wr) begin
            w = j / 4;
            e_data = 32'h0;
            for (int k = 0; k <= j - 4 * w; k++) begin
                a = m_src + 16'(4 * w + k);
                e_data[8 * k +: 8] = mem[a][7:0];
            end
            chk("ob_wr_addr", {16'b0, ob_wr_addr}, {16'b0, m_dst + 16'(w)});
            chk("ob_wr_data", ob_wr_data, e_data);
            chk("ob_wr_strb", {28'b0, ob_wr_strb}, {28'b0, 4'((1 << (j - 4 * w + 1)) - 1)});
        end
        if (psum_rd_en === 1'b1) n_rd++;
        if (ob_wr_en === 1'b1)   n_wr++;
        if (done === 1'b1)       n_done++;
    end

    // drive a one-cycle start; the model accepts it only if the controller is idle
    task automatic start_run(input int len, input logic [15:0] s, input logic [15:0] d, input logic [5:0] sc);
        @(negedge clk);
        start = 1'b1;
        cfg_len = 16'(len);
        cfg_src_base = s;
        cfg_dst_base = d;
        cfg_scale = sc;
        if (!run_valid || cyc > t0 + dur(m_len)) begin
            run_valid = 1'b1;
            t0 = cyc;
            m_len = len;
            m_src = s;
            m_dst = d;
            m_scale = sc;
        end
        @(negedge clk);
        start = 1'b0;
        cfg_len = 16'($urandom);
        cfg_src_base = 16'($urandom);
        cfg_dst_base = 16'($urandom);
        cfg_scale = 6'($urandom);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1;
        run_valid = 1'b0;
        m_scale = 6'h0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (run_valid && cyc <= t0 + dur(m_len) && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_idle_timeout", guard < 1000 ? 32'd0 : 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic fill(input logic [15:0] s, input int len, input logic [31:0] base, input bit rnd);
        logic [15:0] a;
        for (int i = 0; i < len; i++) begin
            a = s + 16'(i);
            mem[a] = rnd ? $urandom : base + 32'(i);
        end
    endtask

    int rd0, wr0, dn0;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = $urandom;
        pd[0] = 8'h0; pd[1] = 8'h0; pd[2] = 8'h0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_scale", {26'b0, ppu_scale}, 32'd0);

        // 1: full words
        fill(16'h0010, 16, 32'd1, 1'b0);
        rd0 = n_rd; wr0 = n_wr; dn0 = n_done;
        start_run(16, 16'h0010, 16'h0040, 6'd5);
        repeat (8) @(negedge clk);
        chk("t1_wr_en", {31'b0, ob_wr_en}, 32'd1);
        chk("t1_wr_addr", {16'b0, ob_wr_addr}, 32'h40);
        chk("t1_word0", ob_wr_data, 32'h04030201);
        chk("t1_strb", {28'b0, ob_wr_strb}, 32'hF);
        wait_idle();
        chk("t1_n_wr", n_wr - wr0, 4);
        chk("t1_n_rd", n_rd - rd0, 16);
        chk("t1_n_done", n_done - dn0, 1);

        // 2: tail word
        fill(16'h0100, 6, 32'hA0, 1'b0);
        start_run(6, 16'h0100, 16'h0200, 6'd1);
        repeat (8) @(negedge clk);
        chk("t2_word0", ob_wr_data, 32'hA3A2A1A0);
        chk("t2_strb0", {28'b0, ob_wr_strb}, 32'hF);
        repeat (2) @(negedge clk);
        chk("t2_word1", ob_wr_data, 32'h0000A5A4);
        chk("t2_strb1", {28'b0, ob_wr_strb}, 32'h3);
        wait_idle();

        // 3: zero length
        rd0 = n_rd; wr0 = n_wr;
        start_run(0, 16'h0300, 16'h0300, 6'd3);
        chk("t3_done_t1", {31'b0, done}, 32'd1);
        wait_idle();
        chk("t3_no_rd", n_rd - rd0, 0);
        chk("t3_no_wr", n_wr - wr0, 0);

        // 4: start while busy, then start during DONE
        fill(16'h0400, 8, 32'h0, 1'b1);
        wr0 = n_wr; rd0 = n_rd;
        start_run(8, 16'h0400, 16'h0500, 6'd7);
        start_run(5, 16'h0900, 16'h0A00, 6'd9);
        while (cyc < t0 + dur(m_len) - 1) @(negedge clk);
        start_run(3, 16'h0B00, 16'h0C00, 6'd11);
        chk("t4_scale", {26'b0, ppu_scale}, 32'd7);
        wait_idle();
        chk("t4_n_wr", n_wr - wr0, 2);
        chk("t4_n_rd", n_rd - rd0, 8);

        // 5: reset mid-run, then a clean short run
        fill(16'h0600, 16, 32'h0, 1'b1);
        start_run(16, 16'h0600, 16'h0700, 6'd4);
        repeat (4) @(negedge clk);
        do_reset(1);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_rd_en", {31'b0, psum_rd_en}, 32'd0);
        chk("t5_wr_en", {31'b0, ob_wr_en}, 32'd0);
        chk("t5_scale", {26'b0, ppu_scale}, 32'd0);
        repeat (10) @(negedge clk);
        fill(16'h0800, 4, 32'h0, 1'b1);
        wr0 = n_wr; dn0 = n_done;
        start_run(4, 16'h0800, 16'h0880, 6'd6);
        wait_idle();
        chk("t5_n_wr", n_wr - wr0, 1);
        chk("t5_n_done", n_done - dn0, 1);

        // 6: address wrap and scale
        fill(16'hFFFE, 4, 32'h0, 1'b1);
        start_run(4, 16'hFFFE, 16'h0020, 6'd2);
        chk("t6_addr0", {16'b0, psum_rd_addr}, 32'hFFFE);
        chk("t6_scale", {26'b0, ppu_scale}, 32'd2);
        repeat (2) @(negedge clk);
        chk("t6_addr2", {16'b0, psum_rd_addr}, 32'h0000);
        @(negedge clk);
        chk("t6_addr3", {16'b0, psum_rd_addr}, 32'h0001);
        wait_idle();

        // randomized runs with occasional extra starts
        for (int r = 0; r < 25; r++) begin
            int len;
            logic [15:0] s;
            len = $urandom_range(0, 20);
            s = 16'($urandom);
            fill(s, len, 32'h0, 1'b1);
            start_run(len, s, 16'($urandom), 6'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, len + 6)) @(negedge clk);
                start_run($urandom_range(0, 20), 16'($urandom), 16'($urandom), 6'($urandom));
            end
            wait_idle();
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
